// File: rtl/nibble_alu_seq.sv
// -----------------------------------------------------------------------------
// nibble_alu_seq
//
// Multi-cycle W-bit ALU (W = 4*NIBBLES) built around one 4-bit ALU slice. The
// slice is reused once per nibble, least-significant nibble first, and the
// carry is held in a register between nibbles. One request is in flight at a
// time; valid/ready handshakes sit on both sides.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high; clears all state
//   start_valid   request present (sampled only in IDLE)
//   start_ready   block can accept a request (IDLE only)
//   op[2:0]       op[2] = invert b and carry-in 1; op[1:0]: 00 AND, 01 OR,
//                 10 ADD, 11 SLT (op 011 is treated as 111)
//   a, b          operands, captured on acceptance
//   result_valid  result/cout/overflow/zero valid (DONE only)
//   result_ready  consumer takes the result
//   result        operation result
//   cout          carry out of the MSB (0 for AND/OR)
//   overflow      signed overflow of the MSB nibble (0 for AND/OR)
//   zero          result == 0
// -----------------------------------------------------------------------------
module nibble_alu_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [2:0]             op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   overflow,
    output logic                   zero
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [2:0]      op_q;
    logic            carry_q;
    logic [IW-1:0]   idx;

    // Slice signals
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [4:0]      sum5;
    logic            c_msb_in;
    logic [3:0]      slice_y;
    logic            slice_c;
    logic            slice_v;

    logic            last;
    logic [W-1:0]    res_next;

    // -------------------------------------------------------------------------
    // 4-bit slice: same op encoding and carry/overflow rules as ALU4Bit.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        slice_y  = '0;
        slice_c  = 1'b0;
        slice_v  = 1'b0;

        a_nib    = a_q[{idx, 2'b00} +: 4];
        b_nib    = op_q[2] ? ~b_q[{idx, 2'b00} +: 4] : b_q[{idx, 2'b00} +: 4];
        sum5     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        // Carry into bit 3 recovered from the sum bit; overflow compares it
        // with the carry out of bit 3.
        c_msb_in = a_nib[3] ^ b_nib[3] ^ sum5[3];

        unique case (op_q[1:0])
            2'b00: slice_y = a_nib & b_nib;
            2'b01: slice_y = a_nib | b_nib;
            default: begin
                slice_y = sum5[3:0];
                slice_c = sum5[4];
                slice_v = c_msb_in ^ sum5[4];
            end
        endcase
    end

    assign last = (idx == LAST);

    // Result register with the current nibble merged in. On the final SLT
    // nibble the whole word is replaced by the signed less-than bit.
    always_comb begin
        res_next                     = result;
        res_next[{idx, 2'b00} +: 4]  = slice_y;
        if (last && (op_q[1:0] == 2'b11)) begin
            res_next = {{(W-1){1'b0}}, slice_y[3] ^ slice_v};
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_valid)  next_state = RUN;
            RUN:     if (last)         next_state = DONE;
            DONE:    if (result_ready) next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: captured operands are reset as well, so an aborted request
            // leaves no trace of its data.
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        // SLT always subtracts, so 011 is folded into 111.
                        op_q    <= (op[1:0] == 2'b11) ? 3'b111 : op;
                        carry_q <= (op[1:0] == 2'b11) ? 1'b1 : op[2];
                        idx     <= '0;
                    end
                end
                RUN: begin
                    result  <= res_next;
                    carry_q <= slice_c;
                    idx     <= idx + 1'b1;
                    if (last) begin
                        cout     <= slice_c;
                        overflow <= slice_v;
                        zero     <= (res_next == '0);
                    end
                end
                default: ;  // DONE holds every output
            endcase
        end
    end

    // Decoded straight from the state register; start_ready is also masked
    // while reset is held.
    assign start_ready  = (state == IDLE) && !reset;
    assign result_valid = (state == DONE);

endmodule

// File: doc/nibble_alu_seq.md
# nibble_alu_seq

Multi-cycle W-bit ALU built around a single 4-bit ALU slice (same op encoding and carry/overflow semantics as the team's ALU4Bit). The slice is time-multiplexed over the operand, least-significant nibble first, with the carry held in a register between nibbles. A valid/ready handshake on each side lets the block sit between a register-file read stage and a writeback stage. It delivers full-width AND, OR, ADD, SUB and signed SLT at one nibble per cycle.

## Interface
- NIBBLES, 4: number of 4-bit slices; W = 4*NIBBLES (default 16). Legal range 2..8.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start_valid  in  1  request present.
- start_ready  out  1  block can accept a request; high only in IDLE.
- op  in  3  op[2] = b-invert and initial carry-in; op[1:0]: 00 AND, 01 OR, 10 ADD, 11 SLT.
- a, b  in  W  operands (two's complement for arithmetic).
- result_valid  out  1  result, cout, overflow and zero are valid; high only in DONE.
- result_ready  in  1  consumer takes the result.
- result  out  W  operation result.
- cout  out  1  carry out of MSB (0 for AND/OR).
- overflow  out  1  signed overflow of the MSB nibble (0 for AND/OR).
- zero  out  1  result == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid, capture a, b and op (op 011 is stored as 111); carry_reg<=op[2], idx<=0; go to RUN.
- Later changes on a, b and op are ignored.
- RUN: each cycle, feed nibble idx of a and b to the slice with carry-in carry_reg and b inverted if op[2].
  - Write the slice's 4-bit output into result nibble idx. carry_reg<=slice cout. idx<=idx+1.
  - On idx==NIBBLES-1: latch cout = slice cout and overflow = carry_in_MSB ^ cout_MSB, then go to DONE.
- AND/OR (op[1:0]=0x): per-nibble a&b' or a|b', where b' = op[2] ? ~b : b. cout and overflow are forced to 0.
- ADD/SUB: W-bit a + b' + op[2]; the result wraps modulo 2^W.
- SLT (op[1:0]=11): compute a - b internally. result = {W-1 zeros, sign_of_difference ^ overflow}, i.e. the signed a<b. cout and overflow report the subtraction.
- zero is computed from the final result register, not from the subtraction.
- DONE: result_valid=1 and all outputs are held stable. On result_ready, go to IDLE. start_valid is ignored outside IDLE.
- Reset (any state, including mid-RUN):
  - state=IDLE, idx=0, carry_reg=0, captured operands=0.
  - result=0, cout=0, overflow=0, zero=0, result_valid=0.
  - start_ready=1 while reset is deasserted in IDLE.
  - An in-flight request is discarded.

## Timing
- Acceptance edge T (start_valid && start_ready). RUN occupies edges T+1..T+NIBBLES; result_valid rises after edge T+NIBBLES (latency NIBBLES cycles).
- Result is consumed on the first edge where result_valid && result_ready. The block is back in IDLE on that edge.
- Next acceptance is no earlier than one cycle later. Minimum issue interval: NIBBLES+2 cycles.
- result_ready held low: the block stays in DONE indefinitely and outputs do not change.
- start_ready and result_valid are never high together.
- Outputs come straight from registers. There is no combinational path from inputs to outputs.

## Test plan
- ADD 0x7FFF+0x0001 (op 010): result 0x8000, overflow 1, cout 0, zero 0; result_valid exactly 4 cycles after acceptance.
- SUB 0x1234-0x1234 (op 110): result 0x0000, zero 1, cout 1, overflow 0. ADD 0x8000+0x8000: result 0x0000, cout 1, overflow 1, zero 1.
- SLT (op 111): 0x8001 vs 0xFFFF gives 0x0001; 0x7FFF vs 0x8000 gives 0x0000 with overflow 1; 0xFFFF vs 0x0000 gives 0x0001; 0x0001 vs 0x0000 gives 0x0000. Op 011 with 0x0000 vs 0x0001 gives 0x0001.
- Logic: op 100, 0xFFFF & ~0x0F0F gives 0xF0F0, cout 0, overflow 0. Op 101, 0x0000 | ~0xFFFF gives 0x0000, zero 1. Op 001, 0x00F0 | 0x0F00 gives 0x0FF0.
- Backpressure: hold result_ready low for 3 cycles in DONE. Outputs stay constant and start_ready stays 0. A start_valid pulse during DONE is not accepted. The next request is accepted only after IDLE is re-entered.
- Reset asserted asynchronously during RUN idx=2: all outputs go to 0 without waiting for a clock edge. After release, start_ready=1, and a new ADD 0x0003+0x0004 returns 0x0007.
